// File: rtl/multicycle_control_pkg.sv
// rtl/multicycle_control_pkg.sv - shared state, opcode and ALU operation codes
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADDR = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXEC    = 4'd7,
    S_RCOMP   = 4'd8,
    S_BRANCH  = 4'd9,
    S_JUMP    = 4'd10
  } state_t;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic op_legal(input logic [5:0] op);
    return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J);
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle datapath control FSM
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Opcode,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] PCSource,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       IllegalOp,
  output logic [3:0] State
);

  state_t state_q;
  state_t state_d;
  logic   mem_rdy;

  // Without the handshake every memory access completes in one cycle.
  assign mem_rdy = MEM_HANDSHAKE ? MemReady : 1'b1;
  assign State   = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_IDLE:    state_d = S_FETCH;
      S_FETCH:   state_d = mem_rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW: state_d = S_MEMADDR;
          OP_R:         state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADDR: state_d = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = mem_rdy ? S_MEMWB : S_MEMRD;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   state_d = mem_rdy ? S_FETCH : S_MEMWR;
      S_EXEC:    state_d = S_RCOMP;
      S_RCOMP:   state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_JUMP:    state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = PCSRC_ALU;
    ALUSrcB     = SRCB_REG;
    ALUOp       = ALUOP_ADD;
    IllegalOp   = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = mem_rdy;
        PCWrite = mem_rdy;
      end
      S_DECODE: begin
        ALUSrcB   = SRCB_IMMSH;
        IllegalOp = !op_legal(Opcode);
      end
      S_MEMADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
      end
      S_RCOMP: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] Opcode;
  logic       MemReady;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic       IRWrite, ALUSrcA, RegWrite, RegDst, IllegalOp;
  logic [1:0] PCSource, ALUSrcB, ALUOp;
  logic [3:0] State;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
    .RegDst(RegDst), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .IllegalOp(IllegalOp), .State(State)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010;

  logic [16:0] dut_ctrl;
  assign dut_ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                     IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB,
                     ALUOp, IllegalOp};

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Control word expected in each state, straight from the state descriptions.
  function automatic logic [16:0] exp_ctrl(input int st, input logic mr, input logic [5:0] op);
    logic pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, m2r = 0, irw = 0;
    logic srca = 0, rw = 0, rdst = 0, ill = 0;
    logic [1:0] pcs = 0, srcb = 0, aop = 0;
    case (st)
      1:  begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
      2:  begin srcb = 2'b11; ill = !(op == LW || op == SW || op == RT || op == BEQ || op == JMP); end
      3:  begin srca = 1; srcb = 2'b10; end
      4:  begin mrd = 1; iord = 1; end
      5:  begin rw = 1; m2r = 1; end
      6:  begin mwr = 1; iord = 1; end
      7:  begin srca = 1; aop = 2'b10; end
      8:  begin rw = 1; rdst = 1; end
      9:  begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      10: begin pcw = 1; pcs = 2'b10; end
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, m2r, irw, srca, rw, rdst, pcs, srcb, aop, ill};
  endfunction

  typedef struct {
    logic [5:0] op;
    int stall;
    int lat;
    int regw;
    int memw;
    int ill;
    int pcw;
  } vec_t;

  // Runs one instruction from a post-edge FETCH sample until the next FETCH.
  task automatic run_instr(input vec_t v, input int idx);
    int cyc = 0, rw = 0, mw = 0, il = 0, pw = 0, viol = 0, stall_left;
    bit done = 0;
    stall_left = v.stall;
    Opcode = v.op;
    while (!done && cyc < 50) begin
      if ((State == 4 || State == 6) && stall_left > 0) begin
        MemReady = 1'b0;
        stall_left--;
      end else begin
        MemReady = 1'b1;
      end
      #1;
      cyc++;
      rw += RegWrite; mw += MemWrite; il += IllegalOp; pw += PCWrite;
      if ((MemWrite && RegWrite) || (MemRead && MemWrite)) viol++;
      @(posedge clk); #1;
      if (State == 4'd1) done = 1;
    end
    check($sformatf("vec%0d latency", idx), cyc, v.lat);
    check($sformatf("vec%0d regwrite cycles", idx), rw, v.regw);
    check($sformatf("vec%0d memwrite cycles", idx), mw, v.memw);
    check($sformatf("vec%0d illegal cycles", idx), il, v.ill);
    check($sformatf("vec%0d pcwrite cycles", idx), pw, v.pcw);
    check($sformatf("vec%0d strobe exclusion", idx), viol, 0);
  endtask

  vec_t vecs[9];
  int   seq_lw[7];
  int   m_cur;
  int   m_path[$];

  initial begin
    vecs[0] = '{LW,       0, 5, 1, 0, 0, 1};
    vecs[1] = '{SW,       0, 4, 0, 1, 0, 1};
    vecs[2] = '{RT,       0, 4, 1, 0, 0, 1};
    vecs[3] = '{BEQ,      0, 3, 0, 0, 0, 1};
    vecs[4] = '{JMP,      0, 3, 0, 0, 0, 2};
    vecs[5] = '{6'h3f,    0, 2, 0, 0, 1, 1};
    vecs[6] = '{6'b001000,0, 2, 0, 0, 1, 1};
    vecs[7] = '{SW,       3, 7, 0, 4, 0, 1};
    vecs[8] = '{LW,       2, 7, 1, 0, 0, 1};
    seq_lw = '{0, 1, 2, 3, 4, 5, 1};

    rst_n = 1'b0; Opcode = LW; MemReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset state", State, 0);
    check("reset outputs", dut_ctrl, 0);

    // lw from reset release with memory always ready
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i == 0) #1;
      else begin @(posedge clk); #1; end
      check($sformatf("lw seq state %0d", i), State, seq_lw[i]);
      check($sformatf("lw seq regwrite %0d", i), RegWrite, seq_lw[i] == 5 && i == 5);
      check($sformatf("lw seq memtoreg %0d", i), MemtoReg, seq_lw[i] == 5 && i == 5);
    end

    foreach (vecs[i]) run_instr(vecs[i], i);

    // asynchronous reset in the middle of a MEMRD wait
    Opcode = LW; MemReady = 1'b1;
    for (int k = 0; k < 20 && State != 4'd4; k++) begin @(posedge clk); #1; end
    check("reached memrd", State, 4);
    MemReady = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("memrd holding", State, 4);
    rst_n = 1'b0;
    #1;
    check("async reset state", State, 0);
    check("async reset outputs", dut_ctrl, 0);
    @(negedge clk); MemReady = 1'b1; rst_n = 1'b1;
    #1;
    check("restart idle", State, 0);
    @(posedge clk); #1;
    check("restart fetch", State, 1);

    // randomized run against the path model
    m_cur = 1;
    m_path = {};
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (m_cur == 1) begin
        case ($urandom_range(0, 6))
          0: Opcode = LW;   1: Opcode = SW;  2: Opcode = RT;
          3: Opcode = BEQ;  4: Opcode = JMP;
          default: Opcode = 6'($urandom);
        endcase
      end
      MemReady = ($urandom_range(0, 3) != 0);
      #1;
      check("rand state", State, m_cur);
      check("rand ctrl", dut_ctrl, exp_ctrl(m_cur, MemReady, Opcode));
      @(posedge clk);
      if ((m_cur == 1 || m_cur == 4 || m_cur == 6) && !MemReady) begin
      end else if (m_cur == 1) begin
        case (Opcode)
          LW:      m_path = {2, 3, 4, 5};
          SW:      m_path = {2, 3, 6};
          RT:      m_path = {2, 7, 8};
          BEQ:     m_path = {2, 9};
          JMP:     m_path = {2, 10};
          default: m_path = {2};
        endcase
        m_cur = m_path.pop_front();
      end else if (m_path.size() == 0) begin
        m_cur = 1;
      end else begin
        m_cur = m_path.pop_front();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
